// File: rtl/cmd_router.sv
// cmd_router: in-order custom-instruction router from one CPU command/response port to NUM_SLV slaves.
//    clk, reset                      : clock, asynchronous active-high reset
//    cmd_*                           : CPU command in (valid/ready, function_id, two operands), cmd_int out
//    rsp_*                           : CPU response out (valid/ready, data)
//    s_cmd_*                         : per-slave command valid/ready, broadcast function_id and operands
//    s_rsp_*                         : per-slave response valid/ready, packed slave data (slave i at [32*i +: 32])
//    s_cmd_int                       : per-slave interrupts, OR-ed onto cmd_int
//    timeout_err                     : sticky watchdog flag
// Optional feature macro CMD_ROUTER_TIMEOUT_EN adds the response watchdog and late-response drop logic.
module cmd_router #(
   parameter int          NUM_SLV     = 2,
   parameter int          SEL_W       = $clog2(NUM_SLV),
   parameter int          OUTSTANDING = 4,
   parameter logic [31:0] ERR_DATA    = 32'hFFFF_FFFF,
   parameter int          TIMEOUT_CYC = 1024
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    cmd_valid,
   input  logic [9:0]              cmd_function_id,
   input  logic [31:0]             cmd_inputs_0,
   input  logic [31:0]             cmd_inputs_1,
   output logic                    cmd_ready,
   output logic                    cmd_int,
   output logic                    rsp_valid,
   output logic [31:0]             rsp_outputs_0,
   input  logic                    rsp_ready,
   output logic [NUM_SLV-1:0]      s_cmd_valid,
   output logic [9:0]              s_cmd_function_id,
   output logic [31:0]             s_cmd_inputs_0,
   output logic [31:0]             s_cmd_inputs_1,
   input  logic [NUM_SLV-1:0]      s_cmd_ready,
   input  logic [NUM_SLV-1:0]      s_rsp_valid,
   input  logic [32*NUM_SLV-1:0]   s_rsp_outputs_0,
   output logic [NUM_SLV-1:0]      s_rsp_ready,
   input  logic [NUM_SLV-1:0]      s_cmd_int,
   output logic                    timeout_err
);
   localparam int PTR_W = $clog2(OUTSTANDING);
   localparam int TAG_W = SEL_W + 1;
   // Tag value NUM_SLV marks a command the router answers itself.
   localparam logic [TAG_W-1:0] ERR_TAG = TAG_W'(NUM_SLV);

   if (NUM_SLV < 2 || NUM_SLV > 16 || OUTSTANDING < 2 || (OUTSTANDING & (OUTSTANDING - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_cfg
      $error("cmd_router: invalid parameter set");
   end

   logic [TAG_W-1:0]   r_tags [OUTSTANDING];
   logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
   logic [PTR_W:0]     r_count;
   logic [SEL_W-1:0]   w_idx;
   logic [TAG_W-1:0]   w_tag, w_head;
   logic [NUM_SLV-1:0] w_sel_oh, w_head_oh, w_drop_act;
   logic [31:0]        w_slv_data;
   logic               w_mapped, w_full, w_empty, w_push, w_pop, w_head_err, w_slv_valid, w_sub;

   assign w_idx      = cmd_function_id[9 -: SEL_W];
   assign w_mapped   = {1'b0, w_idx} < ERR_TAG;
   assign w_tag      = w_mapped ? {1'b0, w_idx} : ERR_TAG;
   assign w_full     = r_count == (PTR_W + 1)'(OUTSTANDING);
   assign w_empty    = r_count == '0;
   assign w_head     = r_tags[r_rd_ptr];
   assign w_head_err = !w_empty & (w_head == ERR_TAG);

   always_comb begin
      w_sel_oh    = '0;
      w_head_oh   = '0;
      w_slv_valid = 1'b0;
      w_slv_data  = '0;
      for (int i = 0; i < NUM_SLV; i++) begin
         w_sel_oh[i]  = w_mapped & (w_idx == SEL_W'(i));
         w_head_oh[i] = !w_empty & (w_head == TAG_W'(i));
         // A slave still owing a dropped response cannot supply the head response.
         w_slv_valid  = w_slv_valid | (w_head_oh[i] & s_rsp_valid[i] & !w_drop_act[i]);
         w_slv_data   = w_slv_data | (w_head_oh[i] ? s_rsp_outputs_0[32*i +: 32] : 32'h0);
      end
   end

   assign cmd_ready         = !w_full & (!w_mapped | |(s_cmd_ready & w_sel_oh));
   assign s_cmd_valid       = (cmd_valid & !w_full) ? w_sel_oh : '0;
   assign s_cmd_function_id = cmd_function_id;
   assign s_cmd_inputs_0    = cmd_inputs_0;
   assign s_cmd_inputs_1    = cmd_inputs_1;
   assign cmd_int           = |s_cmd_int;
   assign w_push            = cmd_valid & cmd_ready;

   assign rsp_valid     = w_head_err | w_sub | w_slv_valid;
   assign rsp_outputs_0 = !rsp_valid ? 32'h0 : (w_head_err | w_sub) ? ERR_DATA : w_slv_data;
   assign w_pop         = rsp_valid & rsp_ready;
   assign s_rsp_ready   = ((rsp_ready & !w_sub) ? w_head_oh : '0) | w_drop_act;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < OUTSTANDING; i++) r_tags[i] <= '0;
      end else begin
         if (w_push) begin
            r_tags[r_wr_ptr] <= w_tag;
            r_wr_ptr         <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (PTR_W + 1)'(w_push) - (PTR_W + 1)'(w_pop);
      end
   end

`ifdef CMD_ROUTER_TIMEOUT_EN
   localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1);
   localparam int DROP_W = PTR_W + 1;

   logic [CNT_W-1:0]  r_wait;
   logic [DROP_W-1:0] r_drop [NUM_SLV];
   logic              r_sub, r_timeout_err, w_waiting, w_fire;

   assign w_sub       = r_sub;
   assign timeout_err = r_timeout_err;
   assign w_waiting   = |w_head_oh & !w_pop & !r_sub;
   assign w_fire      = w_waiting & (r_wait == CNT_W'(TIMEOUT_CYC - 1));

   always_comb begin
      w_drop_act = '0;
      for (int i = 0; i < NUM_SLV; i++) w_drop_act[i] = r_drop[i] != '0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait        <= '0;
         r_sub         <= 1'b0;
         r_timeout_err <= 1'b0;
         for (int i = 0; i < NUM_SLV; i++) r_drop[i] <= '0;
      end else begin
         r_wait <= (w_pop | w_fire) ? '0 : w_waiting ? r_wait + 1'b1 : r_wait;
         if (w_fire) begin
            r_sub         <= 1'b1;
            r_timeout_err <= 1'b1;
         end else if (w_pop) begin
            r_sub <= 1'b0;
         end
         // The abandoned slave's late response is owed to us and swallowed.
         for (int i = 0; i < NUM_SLV; i++)
            r_drop[i] <= r_drop[i] + DROP_W'(w_fire & w_head_oh[i]) - DROP_W'(w_drop_act[i] & s_rsp_valid[i]);
      end
   end
`else
   assign w_sub       = 1'b0;
   assign w_drop_act  = '0;
   assign timeout_err = 1'b0;
`endif
endmodule

// File: tb/tb_cmd_router.sv
// tb_cmd_router: directed stimulus with a queue-based reference model checked every cycle.
module tb_cmd_router;
   localparam int          NS  = 3;
   localparam int          OUT = 4;
   localparam int          TO  = 16;
   localparam logic [31:0] ERR = 32'hFFFF_FFFF;
`ifdef CMD_ROUTER_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              cmd_valid, cmd_ready, cmd_int, rsp_valid, rsp_ready, timeout_err;
   logic [9:0]        cmd_function_id, s_cmd_function_id;
   logic [31:0]       cmd_inputs_0, cmd_inputs_1, rsp_outputs_0, s_cmd_inputs_0, s_cmd_inputs_1;
   logic [NS-1:0]     s_cmd_valid, s_cmd_ready, s_rsp_valid, s_rsp_ready, s_cmd_int;
   logic [32*NS-1:0]  s_rsp_outputs_0;

   always #5 clk = ~clk;

   cmd_router #(.NUM_SLV(NS), .OUTSTANDING(OUT), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_function_id(cmd_function_id),
      .cmd_inputs_0(cmd_inputs_0), .cmd_inputs_1(cmd_inputs_1),
      .cmd_ready(cmd_ready), .cmd_int(cmd_int),
      .rsp_valid(rsp_valid), .rsp_outputs_0(rsp_outputs_0), .rsp_ready(rsp_ready),
      .s_cmd_valid(s_cmd_valid), .s_cmd_function_id(s_cmd_function_id),
      .s_cmd_inputs_0(s_cmd_inputs_0), .s_cmd_inputs_1(s_cmd_inputs_1),
      .s_cmd_ready(s_cmd_ready), .s_rsp_valid(s_rsp_valid),
      .s_rsp_outputs_0(s_rsp_outputs_0), .s_rsp_ready(s_rsp_ready),
      .s_cmd_int(s_cmd_int), .timeout_err(timeout_err)
   );

   int          errors = 0;
   int          checks = 0;
   int          q_tag[$];
   int          m_drop[NS];
   int          m_wait = 0;
   bit          m_sub = 1'b0;
   bit          m_terr = 1'b0;
   logic [31:0] got[$];
   logic [NS-1:0] last_scv;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of destinations (-1 = router-answered) plus watchdog bookkeeping.
   always @(negedge clk) begin
      int idx, h;
      bit full, emp, mapped, e_ready, e_rv, pop;
      logic [NS-1:0] e_scv, e_srr;
      logic [31:0] e_data;
      if (reset) begin
         q_tag.delete();
         m_wait = 0;
         m_sub  = 1'b0;
         m_terr = 1'b0;
         for (int i = 0; i < NS; i++) m_drop[i] = 0;
         chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("rst_timeout_err", 32'(timeout_err), 32'h0);
      end else begin
         idx     = int'(cmd_function_id[9:8]);
         full    = q_tag.size() == OUT;
         emp     = q_tag.size() == 0;
         mapped  = idx < NS;
         e_scv   = (cmd_valid && !full && mapped) ? NS'(1 << idx) : '0;
         e_ready = !full && (mapped ? s_cmd_ready[idx] : 1'b1);
         h       = emp ? -2 : q_tag[0];
         e_rv    = 1'b0;
         e_data  = 32'h0;
         e_srr   = '0;
         for (int i = 0; i < NS; i++) if (m_drop[i] > 0) e_srr[i] = 1'b1;
         if (h == -1) begin
            e_rv   = 1'b1;
            e_data = ERR;
         end else if (h >= 0) begin
            if (m_sub) begin
               e_rv   = 1'b1;
               e_data = ERR;
            end else begin
               if (rsp_ready) e_srr[h] = 1'b1;
               if (s_rsp_valid[h] && m_drop[h] == 0) begin
                  e_rv   = 1'b1;
                  e_data = s_rsp_outputs_0[32*h +: 32];
               end
            end
         end
         chk("cmd_ready", 32'(cmd_ready), 32'(e_ready));
         chk("s_cmd_valid", 32'(s_cmd_valid), 32'(e_scv));
         chk("fid_bcast", 32'(s_cmd_function_id), 32'(cmd_function_id));
         chk("op0_bcast", s_cmd_inputs_0, cmd_inputs_0);
         chk("op1_bcast", s_cmd_inputs_1, cmd_inputs_1);
         chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
         chk("rsp_data", rsp_outputs_0, e_data);
         chk("s_rsp_ready", 32'(s_rsp_ready), 32'(e_srr));
         chk("cmd_int", 32'(cmd_int), 32'(|s_cmd_int));
         chk("timeout_err", 32'(timeout_err), 32'(m_terr));
         if (rsp_valid && rsp_ready) got.push_back(rsp_outputs_0);
         pop = e_rv && rsp_ready;
         if (TO_EN) begin
            for (int i = 0; i < NS; i++) if (m_drop[i] > 0 && s_rsp_valid[i]) m_drop[i]--;
            if (pop) begin
               m_wait = 0;
               m_sub  = 1'b0;
            end else if (h >= 0 && !m_sub) begin
               m_wait++;
               if (m_wait == TO) begin
                  m_sub  = 1'b1;
                  m_terr = 1'b1;
                  m_drop[h]++;
                  m_wait = 0;
               end
            end
         end
         if (pop) void'(q_tag.pop_front());
         if (cmd_valid && e_ready) q_tag.push_back(mapped ? idx : -1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [9:0] fid);
      int n = 0;
      cmd_valid       = 1'b1;
      cmd_function_id = fid;
      cmd_inputs_0    = $urandom;
      cmd_inputs_1    = $urandom;
      @(negedge clk);
      while (!cmd_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      last_scv = s_cmd_valid;
      chk("send_accept", 32'(cmd_ready), 32'h1);
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic slave_rsp(input int s, input logic [31:0] data);
      int n = 0;
      s_rsp_valid[s]              = 1'b1;
      s_rsp_outputs_0[32*s +: 32] = data;
      @(negedge clk);
      while (!s_rsp_ready[s] && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("slave_handshake", 32'(s_rsp_ready[s]), 32'h1);
      step();
      s_rsp_valid[s] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp4 [5];
      int n;
      exp4 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'hA4};
      cmd_valid = 1'b0; cmd_function_id = '0; cmd_inputs_0 = '0; cmd_inputs_1 = '0;
      rsp_ready = 1'b1; s_cmd_ready = '1; s_rsp_valid = '0; s_rsp_outputs_0 = '0; s_cmd_int = '0;
      repeat (2) step();
      reset = 1'b0;
      step();
      // Two slaves in order
      got.delete();
      send(10'h000);
      chk("t1_scv0", 32'(last_scv), 32'h1);
      send(10'h100);
      chk("t1_scv1", 32'(last_scv), 32'h2);
      s_cmd_int = 3'b100;
      slave_rsp(0, 32'h11);
      s_cmd_int = 3'b000;
      slave_rsp(1, 32'h22);
      step();
      chk("t1_count", 32'(got.size()), 32'd2);
      chk("t1_first", got[0], 32'h11);
      chk("t1_second", got[1], 32'h22);
      // Later slave answers first; must wait its turn
      got.delete();
      send(10'h000);
      send(10'h100);
      fork
         slave_rsp(1, 32'h22);
         begin
            repeat (3) begin
               @(negedge clk);
               chk("t2_hold_rv", 32'(rsp_valid), 32'h0);
               chk("t2_hold_srr1", 32'(s_rsp_ready[1]), 32'h0);
            end
            @(posedge clk);
            #1;
            slave_rsp(0, 32'h11);
         end
      join
      step();
      chk("t2_count", 32'(got.size()), 32'd2);
      chk("t2_first", got[0], 32'h11);
      chk("t2_second", got[1], 32'h22);
      // Unmapped index answered by router next cycle
      got.delete();
      send(10'h300);
      chk("t3_scv", 32'(last_scv), 32'h0);
      @(negedge clk);
      chk("t3_rv", 32'(rsp_valid), 32'h1);
      chk("t3_data", rsp_outputs_0, ERR);
      step();
      // Fill the tag FIFO, fifth command stalls until one pop
      got.delete();
      rsp_ready = 1'b0;
      send(10'h000);
      send(10'h100);
      send(10'h2AB);
      send(10'h004);
      cmd_valid = 1'b1;
      cmd_function_id = 10'h100;
      @(negedge clk);
      chk("t4_full_ready", 32'(cmd_ready), 32'h0);
      chk("t4_full_scv", 32'(s_cmd_valid), 32'h0);
      step();
      fork
         send(10'h100);
         begin
            rsp_ready = 1'b1;
            slave_rsp(0, 32'hA0);
         end
      join
      slave_rsp(1, 32'hA1);
      slave_rsp(2, 32'hA2);
      slave_rsp(0, 32'hA3);
      slave_rsp(1, 32'hA4);
      step();
      chk("t4_count", 32'(got.size()), 32'd5);
      for (int i = 0; i < 5; i++) chk("t4_order", got[i], exp4[i]);
      // Reset with commands outstanding
      rsp_ready = 1'b0;
      send(10'h000);
      send(10'h100);
      send(10'h300);
      reset = 1'b1;
      @(negedge clk);
      chk("t5_rv", 32'(rsp_valid), 32'h0);
      chk("t5_terr", 32'(timeout_err), 32'h0);
      step();
      reset = 1'b0;
      cmd_function_id = 10'h100;
      s_cmd_ready = 3'b101;
      @(negedge clk);
      chk("t5_ready_lo", 32'(cmd_ready), 32'h0);
      step();
      s_cmd_ready = '1;
      @(negedge clk);
      chk("t5_ready_hi", 32'(cmd_ready), 32'h1);
      step();
      rsp_ready = 1'b1;
      s_rsp_valid = '1;
      @(negedge clk);
      chk("t5_empty_rv", 32'(rsp_valid), 32'h0);
      chk("t5_empty_srr", 32'(s_rsp_ready), 32'h0);
      step();
      s_rsp_valid = '0;
      step();
`ifdef CMD_ROUTER_TIMEOUT_EN
      // Silent slave: watchdog answers, late response swallowed
      got.delete();
      send(10'h000);
      n = 0;
      @(negedge clk);
      while (!rsp_valid && n < 100) begin
         n++;
         @(negedge clk);
      end
      chk("t6_wait", 32'(n), 32'd16);
      chk("t6_data", rsp_outputs_0, ERR);
      step();
      @(negedge clk);
      chk("t6_terr", 32'(timeout_err), 32'h1);
      step();
      slave_rsp(0, 32'hBAD);
      step();
      chk("t6_swallow", 32'(got.size()), 32'd1);
      send(10'h000);
      slave_rsp(0, 32'h55);
      step();
      chk("t6_count", 32'(got.size()), 32'd2);
      chk("t6_next", got[1], 32'h55);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
